// File: rtl/seg7_scroll_bank.sv
// Scrolling seven-segment message bank: a small register-mapped character buffer
// whose window of NDIG digits rotates left or right on a prescaled time base.
module seg7_scroll_bank #(
    parameter int NDIG      = 8,
    parameter int DEPTH     = 16,
    parameter int PRESCALE  = 50000,
    parameter int RATE_INIT = 250
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       data,
    input  logic              wren,
    output logic [15:0]       q,
    output logic [7*NDIG-1:0] HEX,
    output logic              wrap
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [5:0]      LEN_MAX  = 6'(DEPTH);
    localparam logic [5:0]      LEN_RST  = 6'((NDIG < DEPTH) ? NDIG : DEPTH);
    localparam logic [15:0]     RATE_RST = 16'(RATE_INIT);
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_RATE = 2'd1;
    localparam logic [1:0] OFF_LEN  = 2'd2;

    logic [6:0]    buf_mem [DEPTH];
    logic          en;
    logic          dir;
    logic [15:0]   rate;
    logic [5:0]    len;
    logic [4:0]    pos;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   rate_cnt;

    // Writes are fire-and-forget: wren qualifies ADDR/data for exactly one
    // cycle, there is no ready, and every write completes on that edge.
    logic          wr_buf;
    logic          wr_ctl;
    logic [1:0]    off;
    logic [AW-1:0] buf_idx;

    assign wr_buf  = wren && !ADDR[5];
    assign wr_ctl  = wren && ADDR[5];
    assign off     = ADDR[1:0];
    assign buf_idx = ADDR[AW-1:0];

    logic unused_inputs;
    assign unused_inputs = ^{ADDR, data};

    logic       strobe;
    logic       step;
    logic [4:0] len_m1;

    assign strobe = en && (pre_cnt == PRE_LAST);
    assign step   = strobe && (rate_cnt == rate);
    assign len_m1 = 5'(len - 6'd1);

    logic [4:0] step_pos;
    logic       step_wrap;

    always_comb begin
        step_pos  = pos;
        step_wrap = 1'b0;
        if (!dir) begin
            if (pos == len_m1) begin
                step_pos  = 5'd0;
                step_wrap = 1'b1;
            end else begin
                step_pos = pos + 5'd1;
            end
        end else begin
            if (pos == 5'd0) begin
                step_pos  = len_m1;
                step_wrap = 1'b1;
            end else begin
                step_pos = pos - 5'd1;
            end
        end
    end

    logic [5:0] len_wr;
    logic [4:0] pos_wr;

    always_comb begin
        len_wr = data[5:0];
        if (data[5:0] == 6'd0) begin
            len_wr = 6'd1;
        end else if (data[5:0] > LEN_MAX) begin
            len_wr = LEN_MAX;
        end
        pos_wr = ({1'b0, data[4:0]} >= len) ? 5'd0 : data[4:0];
    end

    // Walk the window incrementally so the modulo stays correct when LEN < NDIG.
    logic [7*NDIG-1:0] hex_next;
    logic [4:0]        idx;

    always_comb begin
        hex_next = '0;
        idx      = pos;
        for (int k = 0; k < NDIG; k++) begin
            hex_next[7*(NDIG-1-k) +: 7] = buf_mem[idx[AW-1:0]];
            idx = (idx == len_m1) ? 5'd0 : idx + 5'd1;
        end
    end

    logic [15:0] rd;

    always_comb begin
        rd = '0;
        if (!ADDR[5]) begin
            rd = {9'd0, buf_mem[buf_idx]};
        end else begin
            case (off)
                OFF_CTRL: rd = {14'd0, dir, en};
                OFF_RATE: rd = rate;
                OFF_LEN:  rd = {10'd0, len};
                default:  rd = {11'd0, pos};
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= 7'h7F;
            end
            en       <= 1'b0;
            dir      <= 1'b0;
            rate     <= RATE_RST;
            len      <= LEN_RST;
            pos      <= 5'd0;
            pre_cnt  <= '0;
            rate_cnt <= 16'd0;
            wrap     <= 1'b0;
            HEX      <= '1;
            q        <= 16'd0;
        end else begin
            wrap <= 1'b0;
            HEX  <= hex_next;
            q    <= rd;

            if (wr_buf) begin
                buf_mem[buf_idx] <= data[6:0];
            end

            // A control write restarts the time base and overrides any step due now.
            if (wr_ctl) begin
                pre_cnt  <= '0;
                rate_cnt <= 16'd0;
                case (off)
                    OFF_CTRL: begin
                        en  <= data[0];
                        dir <= data[1];
                    end
                    OFF_RATE: rate <= data;
                    OFF_LEN: begin
                        len <= len_wr;
                        if ({1'b0, pos} >= len_wr) begin
                            pos <= 5'd0;
                        end
                    end
                    default: pos <= pos_wr;
                endcase
            end else if (en) begin
                pre_cnt <= strobe ? '0 : pre_cnt + PW'(1);
                if (strobe) begin
                    if (step) begin
                        rate_cnt <= 16'd0;
                        pos      <= step_pos;
                        wrap     <= step_wrap;
                    end else begin
                        rate_cnt <= rate_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scroll_bank.sv
// Self-checking bench for seg7_scroll_bank with PRESCALE=1, NDIG=4, DEPTH=8:
// reset state, buffer/register access, left/right scrolling, LEN/POS clamping.
module tb_seg7_scroll_bank;

    localparam int NDIG      = 4;
    localparam int DEPTH     = 8;
    localparam int PRESCALE  = 1;
    localparam int RATE_INIT = 250;

    localparam logic [15:0] A_CTRL = 16'h0020;
    localparam logic [15:0] A_RATE = 16'h0021;
    localparam logic [15:0] A_LEN  = 16'h0022;
    localparam logic [15:0] A_POS  = 16'h0023;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [15:0]       ADDR;
    logic [15:0]       data;
    logic              wren;
    logic [15:0]       q;
    logic [7*NDIG-1:0] HEX;
    logic              wrap;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          cyc_q[$];

    seg7_scroll_bank #(
        .NDIG      (NDIG),
        .DEPTH     (DEPTH),
        .PRESCALE  (PRESCALE),
        .RATE_INIT (RATE_INIT)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ADDR  (ADDR),
        .data  (data),
        .wren  (wren),
        .q     (q),
        .HEX   (HEX),
        .wrap  (wrap)
    );

    // Clock and watchdog
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] hx(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Driver tasks: everything is driven and sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        data = d;
        wren = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] e);
        logic [31:0] ev;
        string       t;
        ADDR = a;
        wren = 1'b0;
        exp_q.push_back({16'd0, e});
        tag_q.push_back(tag);
        tick();
        ev = exp_q.pop_front();
        t  = tag_q.pop_front();
        check_eq(t, {16'd0, q}, ev);
    endtask

    task automatic expect_hex(input string tag, input logic [27:0] h, input int cy);
        exp_q.push_back({4'd0, h});
        tag_q.push_back(tag);
        cyc_q.push_back(cy);
    endtask

    // Scoreboard: each HEX change pops the next expected frame and its cycle.
    task automatic watch(input int ncyc, input int wrap_at);
        logic [31:0] prev;
        logic [31:0] e;
        string       t;
        int          cy;
        prev = {4'd0, HEX};
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            check_eq($sformatf("wrap_c%0d", c), {31'd0, wrap}, (c == wrap_at) ? 32'd1 : 32'd0);
            if ({4'd0, HEX} !== prev) begin
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    t  = tag_q.pop_front();
                    cy = cyc_q.pop_front();
                    check_eq(t, {4'd0, HEX}, e);
                    check_eq({t, "_cycle"}, c, cy);
                end else begin
                    check_eq("hex_unexpected", {4'd0, HEX}, prev);
                end
                prev = {4'd0, HEX};
            end
        end
        check_eq("sb_leftover", exp_q.size(), 0);
        exp_q.delete();
        tag_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        logic [8:0] junk;
        logic [6:0] vals [4];
        vals = '{7'h01, 7'h02, 7'h03, 7'h04};

        // Reset and idle
        Reset = 1'b1;
        wren  = 1'b0;
        ADDR  = A_CTRL;
        data  = 16'd0;
        repeat (2) tick();
        check_eq("rst_hex", {4'd0, HEX}, 32'h0FFFFFFF);
        check_eq("rst_q", {16'd0, q}, 32'd0);
        check_eq("rst_wrap", {31'd0, wrap}, 32'd0);
        Reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            check_eq("idle_wrap", {31'd0, wrap}, 32'd0);
        end
        check_eq("idle_hex", {4'd0, HEX}, 32'h0FFFFFFF);
        check_eq("idle_q", {16'd0, q}, 32'd0);
        rd("rst_rate", A_RATE, 16'(RATE_INIT));
        rd("rst_len", A_LEN, 16'd4);
        rd("rst_pos", A_POS, 16'd0);
        rd("rst_buf5", 16'h0005, 16'h007F);

        // Load message; upper ADDR/data bits are junk and must be ignored
        wr(16'h0001, 16'h007E);
        for (int i = 0; i < 4; i++) begin
            junk = 9'($urandom_range(0, 511));
            wr(16'hA400 | 16'(i), {junk, vals[i]});
            if (i == 1) check_eq("rd_during_wr", {16'd0, q}, 32'h7E);
        end
        wr(A_LEN, 16'hFFC4);
        tick();
        check_eq("load_hex", {4'd0, HEX}, {4'd0, hx(7'h01, 7'h02, 7'h03, 7'h04)});
        rd("buf1", 16'h0401, 16'h0002);

        // Left scroll, RATE=2: step every third cycle, wrap on 3->0
        wr(A_RATE, 16'd2);
        expect_hex("left_p1", hx(7'h02, 7'h03, 7'h04, 7'h01), 4);
        expect_hex("left_p2", hx(7'h03, 7'h04, 7'h01, 7'h02), 7);
        expect_hex("left_p3", hx(7'h04, 7'h01, 7'h02, 7'h03), 10);
        expect_hex("left_p0", hx(7'h01, 7'h02, 7'h03, 7'h04), 13);
        wr(A_CTRL, 16'd1);
        watch(13, 12);

        // Right scroll from pos 0 wraps to LEN-1
        expect_hex("right_p3", hx(7'h04, 7'h01, 7'h02, 7'h03), 4);
        wr(A_CTRL, 16'd3);
        watch(4, 3);
        wr(A_CTRL, 16'd0);
        rd("pos_after_right", A_POS, 16'd3);

        // LEN changes: pos reset, modulo display, clamping
        expect_hex("len2_hex", hx(7'h01, 7'h02, 7'h01, 7'h02), 1);
        wr(A_LEN, 16'd2);
        watch(1, -1);
        rd("len2_pos", A_POS, 16'd0);
        rd("len2_len", A_LEN, 16'd2);
        expect_hex("len1_hex", hx(7'h01, 7'h01, 7'h01, 7'h01), 1);
        wr(A_LEN, 16'd0);
        watch(1, -1);
        rd("len0_clamp", A_LEN, 16'd1);
        expect_hex("len8_hex", hx(7'h01, 7'h02, 7'h03, 7'h04), 1);
        wr(A_LEN, 16'd20);
        watch(1, -1);
        rd("len20_clamp", A_LEN, 16'd8);

        // POS and CTRL writes
        wr(A_POS, 16'hFFE5);
        rd("pos_wr5", A_POS, 16'd5);
        wr(A_POS, 16'h0009);
        rd("pos_wr_oob", A_POS, 16'd0);
        wr(A_CTRL, 16'hFFFE);
        rd("ctrl_mask", A_CTRL, 16'd2);
        rd("rate_rb", A_RATE, 16'd2);

        // RATE=0 steps on every strobe
        wr(A_LEN, 16'd4);
        wr(A_RATE, 16'd0);
        expect_hex("r0_p1", hx(7'h02, 7'h03, 7'h04, 7'h01), 2);
        expect_hex("r0_p2", hx(7'h03, 7'h04, 7'h01, 7'h02), 3);
        expect_hex("r0_p3", hx(7'h04, 7'h01, 7'h02, 7'h03), 4);
        expect_hex("r0_p0", hx(7'h01, 7'h02, 7'h03, 7'h04), 5);
        expect_hex("r0_p1b", hx(7'h02, 7'h03, 7'h04, 7'h01), 6);
        expect_hex("r0_p2b", hx(7'h03, 7'h04, 7'h01, 7'h02), 7);
        wr(A_CTRL, 16'd1);
        watch(7, 4);

        // Reset collides with a buffer write and a wrapping step
        Reset = 1'b1;
        wren  = 1'b1;
        ADDR  = 16'h0002;
        data  = 16'h0011;
        tick();
        Reset = 1'b0;
        wren  = 1'b0;
        check_eq("coll_wrap", {31'd0, wrap}, 32'd0);
        check_eq("coll_hex", {4'd0, HEX}, 32'h0FFFFFFF);
        check_eq("coll_q", {16'd0, q}, 32'd0);
        rd("coll_buf2", 16'h0002, 16'h007F);
        rd("coll_pos", A_POS, 16'd0);
        rd("coll_ctrl", A_CTRL, 16'd0);
        rd("coll_len", A_LEN, 16'd4);
        rd("coll_rate", A_RATE, 16'(RATE_INIT));
        ADDR = A_POS;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("post_rst_wrap", {31'd0, wrap}, 32'd0);
        end
        rd("post_rst_pos", A_POS, 16'd0);

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
